fht_input_loader: RTL and testbench

//  Front-end of the FHT core: accepts a stream of N = 2**N_BIT time samples over a valid/ready

---
 rtl/fht_pkg.sv | 27 ++
 rtl/fht_bitrev_addr.sv | 24 ++
 rtl/fht_input_loader.sv | 119 +++++++++++
 tb/tb_fht_input_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// fht_pkg: values shared by the FHT front-end blocks.
//   A_BIT / N_BIT / D_BIT : default bank address width, log2(frame length), sample width
//   loader_state_t        : input loader FSM states
//   bitrev()              : N_BIT-wide bit reversal of a sample index
package fht_pkg;

  localparam int A_BIT = 8;
  localparam int N_BIT = 10;
  localparam int D_BIT = 16;

  typedef enum logic [2:0] {
    WAIT_DONE,
    LOAD,
    FLUSH,
    START,
    WAIT_ACK
  } loader_state_t;

  function automatic logic [N_BIT-1:0] bitrev(input logic [N_BIT-1:0] n);
    logic [N_BIT-1:0] r;
    for (int i = 0; i < N_BIT; i++) begin
      r[i] = n[N_BIT-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// fht_bitrev_addr: maps a natural-order sample index to its bit-reversed
// storage location, split into a one-hot bank select and a bank address.
//   i_idx  in   N_BIT   natural-order sample index
//   o_we   out  4       one-hot bank select, bit b = bank b (low two reversed bits)
//   o_addr out  A_BIT   word address inside the bank (upper reversed bits)
module fht_bitrev_addr #(
  parameter int N_BIT = 10,
  parameter int A_BIT = 8
) (
  input  logic [N_BIT-1:0] i_idx,
  output logic [3:0]       o_we,
  output logic [A_BIT-1:0] o_addr
);

  logic [N_BIT-1:0] w_rev;

  for (genvar gi = 0; gi < N_BIT; gi++) begin : g_rev
    assign w_rev[gi] = i_idx[N_BIT-1-gi];
  end

  assign o_we   = 4'b0001 << w_rev[1:0];
  assign o_addr = w_rev[N_BIT-1:2];

endmodule

// File: rtl/fht_input_loader.sv
// fht_input_loader: accepts one frame of 2**N_BIT samples over valid/ready,
// writes them bit-reversed into four RAM banks and then pulses start to the
// FHT control. Input is held off until the core reports idle again.
//   iCLK      in   1      clock
//   iRESET    in   1      asynchronous reset, active low
//   iCLR      in   1      synchronous abort of the current frame
//   iDATA     in   D_BIT  input sample
//   iVALID    in   1      iDATA valid
//   oREADY    out  1      sample accepted this cycle when iVALID is high
//   iFHT_RDY  in   1      FHT control idle flag
//   oSTART    out  1      one-cycle start pulse
//   oWE       out  4      one-hot bank write enable
//   oADDR_WR  out  A_BIT  bank write address
//   oDATA_WR  out  D_BIT  bank write data
//   oBUSY     out  1      high whenever the loader is not accepting samples
module fht_input_loader #(
  parameter int A_BIT = fht_pkg::A_BIT,
  parameter int N_BIT = fht_pkg::N_BIT,
  parameter int D_BIT = fht_pkg::D_BIT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iCLR,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic             oSTART,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic             oBUSY
);

  import fht_pkg::*;

  loader_state_t    r_state;
  loader_state_t    w_state_next;
  logic [N_BIT-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_start;
  logic [3:0]       r_we;
  logic [A_BIT-1:0] r_addr;
  logic [D_BIT-1:0] r_data;

  logic             w_xfer;
  logic             w_write;
  logic [3:0]       w_bank_we;
  logic [A_BIT-1:0] w_bank_addr;

  // r_ready mirrors (r_state == LOAD), so it doubles as the accept qualifier
  assign w_xfer  = iVALID & r_ready;
  // an abort on the accepting edge cancels that sample's write
  assign w_write = w_xfer & ~iCLR;

  fht_bitrev_addr #(
    .N_BIT (N_BIT),
    .A_BIT (A_BIT)
  ) u_bitrev_addr (
    .i_idx  (r_cnt),
    .o_we   (w_bank_we),
    .o_addr (w_bank_addr)
  );

  always_comb begin
    w_state_next = r_state;
    if (iCLR) begin
      w_state_next = WAIT_DONE;
    end else begin
      case (r_state)
        WAIT_DONE: if (iFHT_RDY) w_state_next = LOAD;
        LOAD:      if (w_xfer && (&r_cnt)) w_state_next = FLUSH;
        FLUSH:     w_state_next = START;
        START:     w_state_next = WAIT_ACK;
        WAIT_ACK:  if (!iFHT_RDY) w_state_next = WAIT_DONE;
        default:   w_state_next = WAIT_DONE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state <= WAIT_DONE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_start <= 1'b0;
      r_we    <= 4'b0000;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      // flag outputs are registered decodes of the next state
      r_ready <= (w_state_next == LOAD);
      r_busy  <= (w_state_next != LOAD);
      r_start <= (w_state_next == START);
      r_we    <= w_write ? w_bank_we : 4'b0000;
      if (w_write) begin
        r_addr <= w_bank_addr;
        r_data <= iDATA;
      end
      // counter is exactly N_BIT wide, so N-1 wraps to 0 at frame end
      if (iCLR) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign oREADY   = r_ready;
  assign oBUSY    = r_busy;
  assign oSTART   = r_start;
  assign oWE      = r_we;
  assign oADDR_WR = r_addr;
  assign oDATA_WR = r_data;

endmodule

// File: tb/tb_fht_input_loader.sv
module tb_fht_input_loader;

  localparam int NPTS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        fht_rdy;
  logic        start;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fht_input_loader dut (
    .iCLK     (clk),
    .iRESET   (rst_n),
    .iCLR     (clr),
    .iDATA    (data),
    .iVALID   (valid),
    .oREADY   (ready),
    .iFHT_RDY (fht_rdy),
    .oSTART   (start),
    .oWE      (we),
    .oADDR_WR (addr),
    .oDATA_WR (wdata),
    .oBUSY    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // bit reversal of a 10-bit index by plain arithmetic
  function automatic int rev10(input int n);
    int r = 0;
    int x = n;
    for (int i = 0; i < 10; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int         m_n = 0;          // index of the next sample to be accepted
  bit         flush_pend = 0;   // last sample of a frame was just accepted
  int         start_cnt = 0;
  int         wcount = 0;
  int         fid = 0;
  int         mem [4][256];
  int         tag [4][256];
  logic [3:0] obs_we [NPTS];
  logic [7:0] obs_addr [NPTS];

  initial begin
    bit         pre_acc, pre_clr;
    int         pre_n, r, b;
    logic [15:0] pre_data;
    logic [3:0] exp_we;
    logic       exp_start;
    forever begin
      @(posedge clk);
      pre_acc  = valid && ready && rst_n;
      pre_clr  = clr;
      pre_n    = m_n;
      pre_data = data;
      #1;
      if (!rst_n) begin
        m_n = 0;
        flush_pend = 0;
        check("rst_ready", ready, 0);
        check("rst_start", start, 0);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_data", wdata, 0);
        check("rst_busy", busy, 1);
      end else begin
        r = rev10(pre_n);
        exp_we = (pre_acc && !pre_clr) ? 4'(1 << (r % 4)) : 4'b0000;
        check("we", we, exp_we);
        if (exp_we != 0) begin
          check("addr", addr, r / 4);
          check("wdata", wdata, pre_data);
          obs_we[pre_n]   = we;
          obs_addr[pre_n] = addr;
        end
        exp_start = flush_pend && !pre_clr;
        check("start", start, exp_start);
        check("busy", busy, !ready);
        flush_pend = pre_acc && !pre_clr && (pre_n == NPTS - 1);
        if (pre_clr) m_n = 0;
        else if (pre_acc) m_n = (m_n + 1) % NPTS;
        if (start) start_cnt++;
        if (we != 0) begin
          b = (we == 4'b0001) ? 0 : (we == 4'b0010) ? 1 : (we == 4'b0100) ? 2 : 3;
          mem[b][addr] = int'(wdata);
          tag[b][addr] = fid;
          wcount++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame_send(input int cnt, input int gap, input bit clr_last);
    int  sent = 0;
    int  guard = 0;
    bit  acc;
    while (sent < cnt && guard < cnt * 20 + 100) begin
      @(negedge clk);
      valid = ($urandom_range(99) >= gap);
      data  = 16'(sent);
      acc   = valid && ready;
      if (clr_last && acc && sent == cnt - 1) clr = 1'b1;
      @(posedge clk);
      if (acc) sent++;
      guard++;
    end
    if (sent < cnt) check("send_timeout", sent, cnt);
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic wait_start(input int base);
    int k = 0;
    while (start_cnt == base && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (start_cnt == base) check("start_timeout", start_cnt, base + 1);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  task automatic rearm();
    @(negedge clk);
    fht_rdy = 1'b0;
    repeat (3) @(negedge clk);
    fht_rdy = 1'b1;
    wait_ready();
  endtask

  task automatic check_map(input string name);
    int errs = 0;
    int r;
    for (int n = 0; n < NPTS; n++) begin
      r = rev10(n);
      if (mem[r % 4][r / 4] != n || tag[r % 4][r / 4] != fid) errs++;
    end
    check(name, errs, 0);
    $display("frame %0d %s: %0d misplaced samples", fid, name, errs);
  endtask

  typedef struct {
    int         n;
    logic [3:0] we;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int sbase, wbase, cnt;

    vecs[0]  = '{0,    4'b0001, 8'd0};
    vecs[1]  = '{1,    4'b0001, 8'd128};
    vecs[2]  = '{2,    4'b0001, 8'd64};
    vecs[3]  = '{3,    4'b0001, 8'd192};
    vecs[4]  = '{4,    4'b0001, 8'd32};
    vecs[5]  = '{7,    4'b0001, 8'd224};
    vecs[6]  = '{256,  4'b0100, 8'd0};
    vecs[7]  = '{512,  4'b0010, 8'd0};
    vecs[8]  = '{768,  4'b1000, 8'd0};
    vecs[9]  = '{1022, 4'b1000, 8'd127};
    vecs[10] = '{1023, 4'b1000, 8'd255};

    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; data = '0; fht_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("ready_at_release", ready, 0);
    @(posedge clk); #1;
    check("ready_one_after_release", ready, 1);

    // test 1: back-to-back frame
    fid = 1; sbase = start_cnt; wbase = wcount;
    frame_send(NPTS, 0, 0);
    idle();
    wait_start(sbase);
    repeat (3) @(negedge clk);
    check("t1_starts", start_cnt - sbase, 1);
    check("t1_writes", wcount - wbase, NPTS);
    check_map("t1_map");
    for (int i = 0; i < 11; i++) begin
      check("vec_we", obs_we[vecs[i].n], vecs[i].we);
      check("vec_addr", obs_addr[vecs[i].n], vecs[i].addr);
      $display("vec n=%0d we=%b addr=%0d", vecs[i].n, obs_we[vecs[i].n], obs_addr[vecs[i].n]);
    end
    rearm();

    // test 2: random valid gaps
    fid = 2; sbase = start_cnt; wbase = wcount;
    frame_send(NPTS, 30, 0);
    idle();
    wait_start(sbase);
    check("t2_writes", wcount - wbase, NPTS);
    check_map("t2_map");

    // test 3: long transform, ready held off
    cnt = 0;
    repeat (5) begin @(negedge clk); cnt += int'(ready); end
    fht_rdy = 1'b0;
    repeat (5650) begin @(negedge clk); cnt += int'(ready); end
    check("t3_ready_held_low", cnt, 0);
    check("t2_starts", start_cnt - sbase, 1);
    fht_rdy = 1'b1;
    check("t3_ready_before_edge", ready, 0);
    @(posedge clk); #1;
    check("t3_ready_after_edge", ready, 1);
    $display("t3 ready returned after long transform");

    // test 4: abort after 300 samples, then a clean frame
    fid = 3;
    frame_send(300, 0, 0);
    @(negedge clk);
    clr = 1'b1; valid = 1'b1; data = 16'd300;
    @(posedge clk); #1;
    check("t4_no_we_after_clr", we, 0);
    idle();
    fid = 4; sbase = start_cnt; wbase = wcount;
    frame_send(NPTS, 20, 0);
    idle();
    wait_start(sbase);
    repeat (3) @(negedge clk);
    check("t4_starts", start_cnt - sbase, 1);
    check("t4_writes", wcount - wbase, NPTS);
    check_map("t4_map");
    rearm();

    // test 5: abort on the edge accepting the last sample
    fid = 5; sbase = start_cnt; wbase = wcount;
    frame_send(NPTS, 0, 1);
    idle();
    check("t5_wait_done_ready", ready, 0);
    repeat (6) @(negedge clk);
    check("t5_starts", start_cnt - sbase, 0);
    check("t5_writes", wcount - wbase, NPTS - 1);
    $display("t5 abort on last sample done");

    // test 6: asynchronous reset mid-frame
    wait_ready();
    fid = 6;
    frame_send(500, 0, 0);
    #2;
    check("t6_we_before_reset", (we != 0), 1);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_we", we, 0);
    check("t6_async_ready", ready, 0);
    check("t6_async_busy", busy, 1);
    check("t6_async_addr", addr, 0);
    check("t6_async_data", wdata, 0);
    check("t6_async_start", start, 0);
    repeat (3) @(negedge clk);
    fht_rdy = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt += int'(ready); end
    check("t6_wait_core_idle", cnt, 0);
    fht_rdy = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_rearm", ready, 1);
    fid = 7; sbase = start_cnt; wbase = wcount;
    frame_send(NPTS, 30, 0);
    idle();
    wait_start(sbase);
    check("t6_writes", wcount - wbase, NPTS);
    check_map("t6_map");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
